ysyx_23060124_csr_exu: RTL

CSR execute and trap-control unit sitting directly upstream of the CSR register file. It accepts one decoded CSR/ecall/mret instruction at a time from the decode stage over a valid/ready handshake. It reads the addressed CSR, computes the Zicsr result, drives the register file's write and trap strobes, and returns the rd writeback value plus a PC redirect to the writeback stage.

---
 rtl/ysyx_23060124_csr_exu.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_csr_exu.sv
// ============================================================================
// Module      : ysyx_23060124_csr_exu
// Description : CSR execute / trap-control unit (IDLE->READ->EXEC->RESP).
//               Optional illegal-access checking under YSYX_CSR_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060124_csr_exu (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_funct3,
  input  logic        in_ecall,
  input  logic        in_mret,
  input  logic [11:0] in_csr_addr,
  input  logic [4:0]  in_rs1_idx,
  input  logic [31:0] in_rs1_data,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_a5,
  output logic [11:0] csr_addr,
  output logic        csr_wen,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        csr_ecall,
  output logic        csr_mret,
  output logic [31:0] csr_pc,
  output logic [31:0] csr_a5,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef YSYX_CSR_ILLEGAL_EN
  ,
  output logic        out_illegal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_pc;
  logic [2:0]  r_funct3;
  logic        r_ecall;
  logic        r_mret;
  logic [11:0] r_addr;
  logic [4:0]  r_rs1_idx;
  logic [31:0] r_rs1_data;
  logic [4:0]  r_rd;
  logic [31:0] r_a5;
  logic [31:0] r_old;
  logic        r_rd_wen;
  logic [31:0] r_rd_data;
  logic        r_redir;
  logic [31:0] r_redirect_pc;

  logic        w_exec;
  logic        w_is_csr;
  logic        w_writes;
  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_illegal;
  logic        w_rd_wen;

  // ecall/mret take priority, so a CSR op only counts when neither flag is set
  assign w_exec   = (r_state == S_EXEC);
  assign w_is_csr = !r_ecall && !r_mret && (r_funct3[1:0] != 2'b00);
  assign w_writes = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
  assign w_src    = r_funct3[2] ? {27'd0, r_rs1_idx} : r_rs1_data;

  always_comb begin
    w_new = r_old;
    case (r_funct3[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = r_old | w_src;
      2'b11:   w_new = r_old & ~w_src;
      default: w_new = r_old;
    endcase
  end

`ifdef YSYX_CSR_ILLEGAL_EN
  logic w_rw_addr;
  logic w_ro_addr;
  logic r_illegal;

  assign w_rw_addr = (r_addr == 12'h300) || (r_addr == 12'h305) ||
                     (r_addr == 12'h341) || (r_addr == 12'h342);
  assign w_ro_addr = (r_addr == 12'hF11) || (r_addr == 12'hF12);
  assign w_illegal = w_is_csr && (!(w_rw_addr || w_ro_addr) || (w_ro_addr && w_writes));
`else
  assign w_illegal = 1'b0;
`endif

  assign w_rd_wen = w_is_csr && (r_rd != 5'd0) && !w_illegal;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= 32'd0;
      r_funct3      <= 3'd0;
      r_ecall       <= 1'b0;
      r_mret        <= 1'b0;
      r_addr        <= 12'd0;
      r_rs1_idx     <= 5'd0;
      r_rs1_data    <= 32'd0;
      r_rd          <= 5'd0;
      r_a5          <= 32'd0;
      r_old         <= 32'd0;
      r_rd_wen      <= 1'b0;
      r_rd_data     <= 32'd0;
      r_redir       <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_pc       <= in_pc;
        r_funct3   <= in_funct3;
        r_ecall    <= in_ecall;
        r_mret     <= in_mret;
        r_addr     <= in_csr_addr;
        r_rs1_idx  <= in_rs1_idx;
        r_rs1_data <= in_rs1_data;
        r_rd       <= in_rd;
        r_a5       <= in_a5;
      end
      if (r_state == S_READ) begin
        r_old <= csr_rdata;
      end
      // Trap vectors are sampled on the same edge the register file updates,
      // so they still hold their pre-update values here.
      if (w_exec) begin
        r_rd_wen      <= w_rd_wen;
        r_rd_data     <= w_is_csr ? r_old : 32'd0;
        r_redir       <= r_ecall || r_mret;
        r_redirect_pc <= r_ecall ? csr_mtvec : (r_mret ? csr_mepc : 32'd0);
      end
    end
  end

`ifdef YSYX_CSR_ILLEGAL_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_exec) begin
      r_illegal <= w_illegal;
    end
  end

  assign out_illegal = out_valid && r_illegal;
`endif

  // Strobes decode from the state register, so an async reset kills them at once
  assign in_ready       = (r_state == S_IDLE) && rst_n;
  assign csr_addr       = r_addr;
  assign csr_wen        = w_exec && w_is_csr && w_writes && !w_illegal;
  assign csr_wdata      = csr_wen ? w_new : 32'd0;
  assign csr_ecall      = w_exec && r_ecall;
  assign csr_mret       = w_exec && !r_ecall && r_mret;
  assign csr_pc         = r_pc;
  assign csr_a5         = r_a5;
  assign out_valid      = (r_state == S_RESP);
  assign out_rd         = r_rd;
  assign out_rd_wen     = out_valid && r_rd_wen;
  assign out_rd_data    = r_rd_data;
  assign redirect_valid = out_valid && r_redir;
  assign redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire
